// File: rtl/prefetch_fetch_unit_pkg.sv
// Shared defaults and helpers for the prefetching fetch stage.
package prefetch_fetch_unit_pkg;

  localparam int          DEF_ADDR_W   = 32;
  localparam int          DEF_INSTR_W  = 32;
  localparam int          DEF_DEPTH    = 4;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
  localparam int          DEF_PC_INC   = 4;

  // True when one more fetch fits: buffered entries plus fetches still in
  // memory must stay below the queue depth, so every response has a slot.
  function automatic logic has_credit(input int count, input int outstanding, input int depth);
    return (count + outstanding) < depth;
  endfunction

endpackage

// File: rtl/prefetch_fetch_unit_fetch_queue.sv
// Synchronous FIFO used both for the {pc, instr} queue and for the in-flight
// PC tag queue. Flush empties it in one cycle; the head is read straight from
// the storage registers, so a push becomes visible the cycle after it lands.
module fetch_queue #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       empty_o,
  output logic                       full_o
);

  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             push_en;
  logic             pop_en;

  assign empty_o = (count_q == CNT_W'(0));
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // Effective push/pop: reset and flush win, pop on empty is ignored, and a
  // push into a full queue is only taken when the head leaves the same cycle.
  always_comb begin
    pop_en  = 1'b0;
    push_en = 1'b0;
    if (rst || flush_i) begin
      pop_en  = 1'b0;
      push_en = 1'b0;
    end else begin
      pop_en  = pop_i && !empty_o;
      push_en = push_i && (!full_o || pop_en);
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_en) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_en)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push_en, pop_en})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage; contents are don't-care until counted as valid.
  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q] <= wdata_i;
  end

  fetch_queue_chk u_chk (
    .clk   (clk),
    .rst   (rst),
    .push  (push_i),
    .pop   (pop_i),
    .flush (flush_i),
    .full  (full_o)
  );

endmodule

// Overflow checker: the credit scheme must never push into a full queue.
module fetch_queue_chk (
  input logic clk,
  input logic rst,
  input logic push,
  input logic pop,
  input logic flush,
  input logic full
);

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && full && !pop && !flush));

endmodule

// File: rtl/prefetch_fetch_unit.sv
// Prefetching fetch stage: issues up to DEPTH fetches ahead of decode, tags
// each with its PC, queues responses in order and discards responses that
// belong to fetches issued before a taken branch.
module prefetch_fetch_unit
  import prefetch_fetch_unit_pkg::*;
#(
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter int                INSTR_W  = DEF_INSTR_W,
  parameter int                DEPTH    = DEF_DEPTH,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC),
  parameter int                PC_INC   = DEF_PC_INC
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [ADDR_W-1:0]  imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr_out,
  output logic [ADDR_W-1:0]  pc_out
);

  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int ENT_W = ADDR_W + INSTR_W;

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

  logic [CNT_W-1:0]  outstanding;
  logic [CNT_W-1:0]  q_count;
  logic [ADDR_W-1:0] tag_pc;
  logic              tag_empty, tag_full;
  logic [ENT_W-1:0]  q_rdata;
  logic              q_empty, q_full;
  logic              unused_flags;

  logic req_fire, rsp_fire, rsp_keep, pop_fire;

  // The tag queue occupancy is the number of fetches still in memory.
  assign unused_flags   = tag_empty ^ tag_full ^ q_full;
  assign imem_req_valid = !rst && !branch_taken &&
                          has_credit(int'(q_count), int'(outstanding), DEPTH);
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign rsp_fire       = imem_rsp_valid && !rst;
  assign rsp_keep       = rsp_fire && (drop_cnt_q == CNT_W'(0)) && !branch_taken;
  assign instr_valid    = !q_empty;
  assign pop_fire       = instr_valid && instr_ready && !branch_taken;

  // Next fetch address: a branch redirects, an accepted request advances.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (branch_taken) begin
      fetch_pc_d = branch_target;
    end else if (req_fire) begin
      fetch_pc_d = fetch_pc_q + ADDR_W'(PC_INC);
    end else begin
      fetch_pc_d = fetch_pc_q;
    end
  end

  // On a branch every fetch left in memory becomes stale; older pending
  // drops are already part of that in-flight total.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (branch_taken) begin
      drop_cnt_d = outstanding - CNT_W'(rsp_fire);
    end else if (rsp_fire && (drop_cnt_q != CNT_W'(0))) begin
      drop_cnt_d = drop_cnt_q - CNT_W'(1);
    end else begin
      drop_cnt_d = drop_cnt_q;
    end
  end

  // Fetch PC and drop counter state.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      drop_cnt_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // In-flight PC tags: never flushed, so stale responses still retire their tag.
  fetch_queue #(.WIDTH(ADDR_W), .DEPTH(DEPTH)) u_tag_q (
    .clk     (clk),
    .rst     (rst),
    .flush_i (1'b0),
    .push_i  (req_fire),
    .wdata_i (fetch_pc_q),
    .pop_i   (rsp_fire),
    .rdata_o (tag_pc),
    .count_o (outstanding),
    .empty_o (tag_empty),
    .full_o  (tag_full)
  );

  // Decoded-side queue of {pc, instr}; a branch clears it.
  fetch_queue #(.WIDTH(ENT_W), .DEPTH(DEPTH)) u_instr_q (
    .clk     (clk),
    .rst     (rst),
    .flush_i (branch_taken),
    .push_i  (rsp_keep),
    .wdata_i ({tag_pc, imem_rsp_data}),
    .pop_i   (pop_fire),
    .rdata_o (q_rdata),
    .count_o (q_count),
    .empty_o (q_empty),
    .full_o  (q_full)
  );

  // Head presentation; outputs read as zero whenever nothing is queued.
  always_comb begin
    instr_out = '0;
    pc_out    = '0;
    if (q_empty) begin
      instr_out = '0;
      pc_out    = '0;
    end else begin
      instr_out = q_rdata[INSTR_W-1:0];
      pc_out    = q_rdata[ENT_W-1:INSTR_W];
    end
  end

endmodule
